// File: rtl/jtag_user_dr_regfile.sv
// JTAG user data-register engine behind a BSCANE2 TAP wrapper, clocked by tck.
// Each DR scan carries one framed {data, addr, wr} transaction into a small control regfile.
module jtag_user_dr_regfile #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 2,
  parameter int unsigned       NUM_REGS = 4,
  parameter logic [DATA_W-1:0] REG_INIT = '0
) (
  input  logic                         tck,
  input  logic                         jtag_rst_n,
  input  logic                         tap_reset,
  input  logic                         capture_dr,
  input  logic                         shift_dr,
  input  logic                         update_dr,
  input  logic                         tdi,
  output logic                         tdo,
  input  logic [NUM_REGS*DATA_W-1:0]   rd_data,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic                         wr_stb,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         err
);

  localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);

  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(FRAME_W + 1);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              wr;
  } frame_t;

  logic [FRAME_W-1:0] sr;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic [DATA_W-1:0]  rd_word;
  frame_t             frame;
  logic               frame_ok;
  logic               addr_ok;
  logic               commit;

  assign tdo      = sr[0];
  assign frame    = sr;
  assign addr_ok  = ({1'b0, frame.addr} < NUM_REGS_W);

  // Only one TAP event acts per cycle; priority tap_reset > capture > shift > update.
  assign frame_ok = !tap_reset && !capture_dr && !shift_dr && update_dr && (cnt == CNT_FULL);
  assign commit   = frame_ok && addr_ok && frame.wr;

  // Readback mux; unimplemented addresses read as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (rd_ptr == ADDR_W'(i)) rd_word = rd_data[i*DATA_W +: DATA_W];
    end
  end

  // Scan chain, bit counter, read pointer and status.
  always_ff @(posedge tck or negedge jtag_rst_n) begin
    if (!jtag_rst_n) begin
      sr      <= '0;
      cnt     <= '0;
      rd_ptr  <= '0;
      err     <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (tap_reset) begin
        sr  <= '0;
        cnt <= '0;
        err <= 1'b0;
      end else if (capture_dr) begin
        // err is read-to-clear: its old value leaves on the first tdo bit.
        sr  <= {rd_word, rd_ptr, err};
        cnt <= '0;
        err <= 1'b0;
      end else if (shift_dr) begin
        sr <= {tdi, sr[FRAME_W-1:1]};
        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      end else if (update_dr) begin
        if (cnt == CNT_FULL) begin
          rd_ptr <= frame.addr;
          if (!addr_ok) begin
            err <= 1'b1;
          end else if (frame.wr) begin
            wr_addr <= frame.addr;
            wr_stb  <= 1'b1;
          end
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  // Control registers; tap_reset deliberately leaves them intact.
  always_ff @(posedge tck or negedge jtag_rst_n) begin
    if (!jtag_rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= REG_INIT;
    end else if (commit) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (frame.addr == ADDR_W'(i)) regs[i] <= frame.data;
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_reg_q
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_jtag_user_dr_regfile.sv
// Randomized scan-level bench for jtag_user_dr_regfile against a transaction-level model.
// Model tracks registers, read pointer, error flag and expected strobe per scan.
module tb_jtag_user_dr_regfile;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned NUM_REGS = 3;
  localparam int unsigned FRAME_W  = 11;

  logic        tck = 1'b0;
  logic        jtag_rst_n;
  logic        tap_reset, capture_dr, shift_dr, update_dr, tdi;
  logic        tdo;
  logic [23:0] rd_data;
  logic [23:0] reg_q;
  logic        wr_stb;
  logic [1:0]  wr_addr;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_regs [NUM_REGS];
  int         m_ptr;
  logic       m_err;
  logic [1:0] m_waddr;
  logic       m_stb;

  jtag_user_dr_regfile #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .REG_INIT(8'h00)
  ) dut (
    .tck(tck), .jtag_rst_n(jtag_rst_n), .tap_reset(tap_reset),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .tdi(tdi), .tdo(tdo), .rd_data(rd_data), .reg_q(reg_q),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .err(err)
  );

  always #5 tck = ~tck;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  function automatic logic [23:0] m_regq();
    logic [23:0] v = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) v[i*8 +: 8] = m_regs[i];
    return v;
  endfunction

  function automatic logic [7:0] m_rdword(input int ptr);
    logic [7:0] w = '0;
    if (ptr < int'(NUM_REGS)) w = rd_data[ptr*8 +: 8];
    return w;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < int'(NUM_REGS); i++) m_regs[i] = 8'h00;
    m_ptr = 0; m_err = 1'b0; m_waddr = 2'd0; m_stb = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_reg_q"},   32'(reg_q),   32'(m_regq()));
    check_eq({tag, "_err"},     32'(err),     32'(m_err));
    check_eq({tag, "_wr_addr"}, 32'(wr_addr), 32'(m_waddr));
    check_eq({tag, "_wr_stb"},  32'(wr_stb),  32'(m_stb));
    if (m_stb) begin
      m_stb = 1'b0;
      tick();
      check_eq({tag, "_stb_drop"}, 32'(wr_stb), 32'd0);
    end
  endtask

  // Capture, shift n bits of 'bits', optionally update; returns the shifted-out stream.
  task automatic do_scan(input string tag, input logic [11:0] bits, input int n,
                         input bit upd, output logic [11:0] got);
    logic [11:0] exp_out;
    logic [11:0] mask;
    int          m;
    exp_out = {1'b0, m_rdword(m_ptr), 2'(m_ptr), m_err};
    capture_dr = 1'b1; tick(); capture_dr = 1'b0;
    m_err = 1'b0;
    check_eq({tag, "_err_rtc"}, 32'(err), 32'd0);
    got = '0;
    for (int i = 0; i < n; i++) begin
      got[i] = tdo;
      tdi = bits[i]; shift_dr = 1'b1; tick();
    end
    shift_dr = 1'b0; tdi = 1'b0;
    m = (n < int'(FRAME_W)) ? n : int'(FRAME_W);
    mask = 12'((1 << m) - 1);
    check_eq({tag, "_tdo"}, 32'(got & mask), 32'(exp_out & mask));
    if (upd) begin
      update_dr = 1'b1; tick(); update_dr = 1'b0;
      if (n == int'(FRAME_W)) begin
        m_ptr = int'(bits[2:1]);
        if (m_ptr >= int'(NUM_REGS)) m_err = 1'b1;
        else if (bits[0]) begin
          m_regs[m_ptr] = bits[10:3];
          m_waddr = bits[2:1];
          m_stb = 1'b1;
        end
      end else begin
        m_err = 1'b1;
      end
    end
    check_state(tag);
  endtask

  initial begin
    logic [11:0] got;
    logic [11:0] frame;
    int          n;
    jtag_rst_n = 1'b0; tap_reset = 1'b0; capture_dr = 1'b0;
    shift_dr = 1'b0; update_dr = 1'b0; tdi = 1'b0; rd_data = '0;
    m_reset();
    repeat (2) tick();
    jtag_rst_n = 1'b1;
    tick();

    // 1: reset values and an all-zero readback
    check_eq("rst_tdo", 32'(tdo), 32'd0);
    check_state("rst");
    do_scan("t1", 12'h000, 11, 1'b0, got);
    check_eq("t1_stream", 32'(got), 32'h000);

    // 2: write 0xB4 to reg 1
    do_scan("t2", 12'h5A3, 11, 1'b1, got);
    check_eq("t2_reg1", 32'(reg_q[15:8]), 32'hB4);

    // 3: two-scan read of word 2
    rd_data = 24'h3C_00_00;
    do_scan("t3a", {1'b0, 8'h00, 2'b10, 1'b0}, 11, 1'b1, got);
    do_scan("t3b", 12'h000, 11, 1'b0, got);
    check_eq("t3_stream", 32'(got[10:0]), 32'h1E4);

    // 4: short scan flags error, read-to-clear on next capture
    do_scan("t4a", 12'h7FF, 10, 1'b1, got);
    check_eq("t4_err", 32'(err), 32'd1);
    do_scan("t4b", 12'h000, 11, 1'b0, got);
    check_eq("t4_errbit", 32'(got[0]), 32'd1);

    // 5: out-of-range address write is rejected but moves rd_ptr
    do_scan("t5a", {1'b0, 8'hFF, 2'b11, 1'b1}, 11, 1'b1, got);
    do_scan("t5b", 12'h000, 11, 1'b0, got);
    check_eq("t5_stream", 32'(got[10:0]), 32'h007);

    // 6: tap_reset mid-shift loses the partial frame
    capture_dr = 1'b1; tick(); capture_dr = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 5; i++) begin tdi = 1'b1; shift_dr = 1'b1; tick(); end
    shift_dr = 1'b0;
    tap_reset = 1'b1; tick(); tap_reset = 1'b0;
    check_eq("t6_tdo_clr", 32'(tdo), 32'd0);
    update_dr = 1'b1; tick(); update_dr = 1'b0;
    m_err = 1'b1;
    check_state("t6");

    // Randomized scans, including bad lengths and occasional async reset
    for (int it = 0; it < 80; it++) begin
      rd_data = 24'($urandom());
      frame   = 12'($urandom());
      case ($urandom_range(0, 9))
        0: n = 10;
        1: n = 12;
        2: n = 3;
        default: n = 11;
      endcase
      do_scan("rnd", frame, n, ($urandom_range(0, 7) != 0), got);
      if ($urandom_range(0, 19) == 0) begin
        jtag_rst_n = 1'b0; #2;
        m_reset();
        check_state("arst");
        jtag_rst_n = 1'b1;
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
